// File: rtl/imem_boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// frame geometry constants and a frame-length helper.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Ports: none (package).
package imem_boot_pkg;

  // Frame layout: 2 header bytes (LE word count), 4 bytes per word, 1 checksum byte.
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int CSUM_BYTES     = 1;

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    CSUM = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } boot_state_t;

  // Total number of bytes in a frame carrying `count` words.
  function automatic int frame_bytes(input int count);
    return HDR_BYTES + BYTES_PER_WORD * count + CSUM_BYTES;
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Bundles the boot byte stream, the imem write port and the core status lines.
// Latency: n/a (wires only). Backpressure: rx_ready qualifies rx_valid.
// Modports: master = stream source / system side, slave = boot loader.
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 8
);

  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  core_rstn;
  logic                  done;
  logic                  error;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, core_rstn, done, error
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, core_rstn, done, error
  );

endinterface

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words (first byte -> bits 7:0).
// Latency: word_valid/word are combinational with the 4th byte of each word.
// Backpressure: none; the caller only presents bytes that are actually accepted.
// Ports: clock, rst (sync, active-high, clears partial word),
//        byte_valid/byte_data in, word_valid/word out.
module byte_word_packer
  import imem_boot_pkg::*;
(
  input  logic        clock,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam int SHIFT_W = (BYTES_PER_WORD - 1) * 8;

  logic [SHIFT_W-1:0] shift_q;
  logic [1:0]         cnt_q;

  // Bytes enter at the top and move down, so after three bytes the first one
  // sits in bits 7:0 and the current byte completes the word as its MSB.
  assign word_valid = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word       = {byte_data, shift_q};

  always_ff @(posedge clock) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid) begin
      shift_q <= {byte_data, shift_q[SHIFT_W-1:8]};
      cnt_q   <= cnt_q + 2'd1;   // wraps to 0 after the 4th byte
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses [count_lo count_hi | count x 4-byte LE words | xor checksum]
// and writes the words into imem, holding the core in reset until the image verifies.
// Latency: imem_we one cycle after the 4th byte; done/core_rstn one cycle after checksum.
// Backpressure: rx_ready high in HDR0/HDR1/DATA/CSUM, low in DONE/ERR and right after rst.
// Ports: clock, rst (sync, active-high), bus (imem_boot_loader_if.slave).
// Optional: define BOOT_TIMEOUT_EN to enable the inter-byte idle timeout
//           (TIMEOUT_CYCLES parameter exists only in that build).
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
`ifdef BOOT_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic              clock,
  input  logic              rst,
  imem_boot_loader_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // One extra bit so a full image (count == DEPTH) is counted without wrapping.
  localparam int IDX_W = ADDR_WIDTH + 1;

  boot_state_t state, state_next;

  logic [15:0]           count, count_next;
  logic [7:0]            csum, csum_next;
  logic [IDX_W-1:0]      word_idx, word_idx_next;

  logic                  rx_ready_q;
  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic [31:0]           imem_wdata_q;
  logic                  core_rstn_q;
  logic                  done_q;
  logic                  error_q;

  logic                  accept;
  logic                  pack_valid;
  logic                  word_valid;
  logic [31:0]           word;
  logic [15:0]           hdr_count;

`ifdef BOOT_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [IDLE_W-1:0]     idle, idle_next;
`endif

  assign accept     = rx_ready_q && bus.rx_valid;
  assign pack_valid = accept && (state == DATA);
  // Full word count as it will be once the byte in HDR1 is taken.
  assign hdr_count  = {bus.rx_data, count[7:0]};

  byte_word_packer u_packer (
    .clock      (clock),
    .rst        (rst),
    .byte_valid (pack_valid),
    .byte_data  (bus.rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_next    = state;
    count_next    = count;
    csum_next     = csum;
    word_idx_next = word_idx;

    case (state)
      HDR0: begin
        if (accept) begin
          count_next[7:0] = bus.rx_data;
          csum_next       = csum ^ bus.rx_data;
          state_next      = HDR1;
        end
      end
      HDR1: begin
        if (accept) begin
          count_next[15:8] = bus.rx_data;
          csum_next        = csum ^ bus.rx_data;
          if (int'(hdr_count) > DEPTH) begin
            state_next = ERR;
          end else if (hdr_count == 16'd0) begin
            state_next = CSUM;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          csum_next = csum ^ bus.rx_data;
          if (word_valid) begin
            word_idx_next = word_idx + IDX_W'(1);
            if (int'(word_idx) + 1 == int'(count)) begin
              state_next = CSUM;
            end
          end
        end
      end
      CSUM: begin
        // The checksum byte itself is compared, never folded in.
        if (accept) begin
          state_next = (bus.rx_data == csum) ? DONE : ERR;
        end
      end
      default: ;  // DONE and ERR are sticky until rst
    endcase

`ifdef BOOT_TIMEOUT_EN
    // Idle counting only once a frame has started; HDR0 may wait forever.
    idle_next = '0;
    if ((state == HDR1 || state == DATA || state == CSUM) && !accept) begin
      if (idle == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        state_next = ERR;
      end else begin
        idle_next = idle + IDLE_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state        <= HDR0;
      count        <= '0;
      csum         <= '0;
      word_idx     <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rstn_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      csum       <= csum_next;
      word_idx   <= word_idx_next;
      // Outputs are registered from the next state so they line up with it.
      rx_ready_q <= (state_next == HDR0) || (state_next == HDR1) ||
                    (state_next == DATA) || (state_next == CSUM);
      imem_we_q  <= word_valid;
      if (word_valid) begin
        imem_addr_q  <= word_idx[ADDR_WIDTH-1:0];
        imem_wdata_q <= word;
      end
      done_q      <= (state_next == DONE);
      core_rstn_q <= (state_next == DONE);
      error_q     <= (state_next == ERR);
    end
  end

`ifdef BOOT_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (rst) begin
      idle <= '0;
    end else begin
      idle <= idle_next;
    end
  end
`endif

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.core_rstn  = core_rstn_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;

endmodule
